tile_scan_mux: RTL and testbench
================================

Name: tile_scan_mux

Overview:
- Parametrised N-channel output selector and scan sequencer for the micro-tile container. It generalises the fixed 4-way sensor/TDC/RO select.
- Manual mode: registered select of one channel, chosen by sel_i.
- Auto mode: round-robins all channels with a programmable dwell time. Each capture is flagged with a valid pulse and a channel tag.
- Sits between the sensor/TDC/RO tiles and uo_out.

Parameters:
- NUM_CH, 4, number of input channels (2..16)
- DATA_W, 8, width of each channel and of data_o
- SEL_W, $clog2(NUM_CH), width of sel_i / ch_o
- DWELL_W, 8, width of dwell_i and the dwell counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ch_data_i  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- mode_i  in  1  0 = manual, 1 = auto scan
- sel_i  in  SEL_W  manual channel select
- dwell_i  in  DWELL_W  auto settle cycles minus one, per channel
- hold_i  in  1  freeze auto scan
- data_o  out  DATA_W  captured/selected channel data (registered)
- ch_o  out  SEL_W  channel index belonging to data_o
- valid_o  out  1  one-cycle pulse per auto capture
- scan_done_o  out  1  one-cycle pulse with valid_o on capture of channel NUM_CH-1

Behaviour:
- One clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset values: data_o=0, ch_o=0, valid_o=0, scan_done_o=0, state=IDLE, cnt=0, ch=0, dwell_lat=0.
- All outputs are registered.
- Manual (state IDLE, mode_i=0):
  - Every cycle, data_o<=ch_data_i[sel_i], ch_o<=sel_i; latency 1 cycle.
  - If sel_i>=NUM_CH: data_o<=0, ch_o<=sel_i.
  - valid_o and scan_done_o stay 0.
- FSM states: IDLE, SETTLE, CAPTURE.
- IDLE -> SETTLE when mode_i=1: cnt<=0, ch<=0, dwell_lat<=dwell_i. data_o/ch_o hold their last value.
- SETTLE:
  - If hold_i: no change.
  - Else if cnt==dwell_lat: go to CAPTURE.
  - Else cnt<=cnt+1.
- CAPTURE (exactly one cycle; hold_i is ignored here):
  - data_o<=ch_data_i[ch], ch_o<=ch, valid_o<=1.
  - scan_done_o<=(ch==NUM_CH-1).
  - ch<=(ch==NUM_CH-1)?0:ch+1, cnt<=0, dwell_lat<=dwell_i, return to SETTLE.
- valid_o/scan_done_o are high in the cycle after CAPTURE, then drop.
- Timing:
  - First valid_o goes high dwell_i+2 edges after the edge that samples mode_i=1.
  - Capture period is dwell_i+2 cycles.
  - dwell_i=0 gives a period of 2.
- dwell_i changes take effect only at the next channel (latched at SETTLE entry).
- mode_i 1->0 in any state: next state IDLE, ch<=0, no valid_o; the manual path resumes the following cycle.
- hold_i deasserts: counting resumes from the frozen cnt; the frozen channel is not skipped.
- Reset mid-scan: immediate return to reset values.
- Counter never wraps: cnt<=dwell_lat is guaranteed by the compare.

Optional Feature:
- Macro TILE_SCAN_SYNC_EN.
- Defined:
  - Each bit of ch_data_i passes through a 2-flop synchroniser (reset 0) before muxing. Tile outputs such as the TDC come from other clock domains.
  - Manual latency becomes 3 cycles; auto FSM timing is unchanged.
  - The captured value is ch_data_i as it was 2 cycles before CAPTURE.
- Undefined: direct path, manual latency 1.

Decomposition:
- Package tile_scan_pkg: state enum (IDLE, SETTLE, CAPTURE), MODE_MANUAL=1'b0, MODE_AUTO=1'b1, and a channel-slice helper function.
- Sub-module tile_scan_sync: parametrised-width 2-flop synchroniser with async active-low reset. Instantiated only under TILE_SCAN_SYNC_EN.

Test Plan:
- Reset asserted mid-scan (channel 2, cnt=3) -> all outputs 0 asynchronously, before the next clk edge; after release, manual mode resumes with ch_o=0.
- Manual, channels = 8'h11/22/33/44, sel_i=2 -> data_o=8'h33, ch_o=2 one edge later, valid_o=0; sel_i switch 2->0 -> 8'h11 next edge.
- Auto, dwell_i=2, data as above -> valid_o every 4 cycles, first 4 edges after mode_i sampled high.
  - Captured data_o/ch_o sequence: 11/0, 22/1, 33/2, 44/3, 11/0.
  - scan_done_o high only with the 44/3 capture.
- Auto, hold_i high for 5 cycles during channel 1 SETTLE -> next valid_o delayed exactly 5 cycles, still ch_o=1, no channel skipped.
- Auto, dwell_i changed 2->5 during channel 0 SETTLE -> channel 0 period 4; channel 1 period 7.
- mode_i dropped during CAPTURE-pending SETTLE of channel 3 -> no valid_o, ch restarts at 0 on re-entry; with TILE_SCAN_SYNC_EN, manual data_o follows ch_data_i 3 edges later.

Source files
------------

// File: rtl/tile_scan_pkg.sv
// tile_scan_pkg
// Shared types and helpers for the tile output scan multiplexer.
//   state_t     : scan sequencer states (IDLE, SETTLE, CAPTURE)
//   MODE_MANUAL : mode_i value selecting the registered manual select
//   MODE_AUTO   : mode_i value selecting the round-robin scan
//   ch_lsb()    : LSB position of channel ch inside the packed channel bus
package tile_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Channel c occupies bits [c*data_w +: data_w] of the packed bus.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned data_w);
        return ch * data_w;
    endfunction

endpackage

// File: rtl/tile_scan_sync.sv
// tile_scan_sync
// Two-flop synchroniser of arbitrary width, reset to zero. Used to bring tile
// outputs produced in other clock domains (e.g. the TDC) into clk.
// Ports:
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset
//   din    : asynchronous input bus, WIDTH bits
//   dout   : synchronised output bus, WIDTH bits (2 cycles of latency)
module tile_scan_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
        end
    end

    assign dout = sync_r;

endmodule

// File: rtl/tile_scan_mux.sv
// tile_scan_mux
// N-channel output selector and scan sequencer between the sensor/TDC/RO
// tiles and uo_out.
//   Manual (mode_i=0): data_o/ch_o register the channel chosen by sel_i.
//   Auto   (mode_i=1): round-robin over all channels; each channel settles for
//                      dwell_i+1 cycles, then is captured with a valid_o pulse.
// Optional build macro: TILE_SCAN_SYNC_EN inserts a 2-flop synchroniser on
// every bit of ch_data_i ahead of the muxes (manual latency becomes 3).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   ch_data_i     : NUM_CH*DATA_W packed channel data
//   mode_i        : 0 manual, 1 auto scan
//   sel_i         : manual channel select (out-of-range selects give 0)
//   dwell_i       : settle cycles minus one, latched at SETTLE entry
//   hold_i        : freezes the settle counter
//   data_o, ch_o  : registered data and its channel index
//   valid_o       : one-cycle pulse per auto capture
//   scan_done_o   : one-cycle pulse with valid_o for channel NUM_CH-1
module tile_scan_mux
    import tile_scan_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = $clog2(NUM_CH),
    parameter int DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    input  logic                     mode_i,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic [DWELL_W-1:0]       dwell_i,
    input  logic                     hold_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [SEL_W-1:0]         ch_o,
    output logic                     valid_o,
    output logic                     scan_done_o
);

    localparam logic [SEL_W:0]   NUM_CH_L = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

    logic [NUM_CH*DATA_W-1:0] ch_bus_s;
    logic [DATA_W-1:0]        ch_arr_s [NUM_CH];
    logic [DATA_W-1:0]        manual_data_s;
    logic [DATA_W-1:0]        auto_data_s;

    state_t               state_r,     state_nx_s;
    logic [DWELL_W-1:0]   cnt_r,       cnt_nx_s;
    logic [DWELL_W-1:0]   dwell_lat_r, dwell_lat_nx_s;
    logic [SEL_W-1:0]     ch_r,        ch_nx_s;
    logic [DATA_W-1:0]    data_r,      data_nx_s;
    logic [SEL_W-1:0]     ch_out_r,    ch_out_nx_s;
    logic                 valid_r,     valid_nx_s;
    logic                 done_r,      done_nx_s;

`ifdef TILE_SCAN_SYNC_EN
    tile_scan_sync #(
        .WIDTH (NUM_CH * DATA_W)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ch_data_i),
        .dout  (ch_bus_s)
    );
`else
    assign ch_bus_s = ch_data_i;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_slice
        assign ch_arr_s[c] = ch_bus_s[ch_lsb(c, DATA_W) +: DATA_W];
    end

    // Manual select; indices past the last channel read as zero.
    always_comb begin
        manual_data_s = {DATA_W{1'b0}};
        if ({1'b0, sel_i} < NUM_CH_L) begin
            manual_data_s = ch_arr_s[sel_i];
        end else begin
            manual_data_s = {DATA_W{1'b0}};
        end
    end

    // ch_r never exceeds LAST_CH, so no range guard is needed here.
    assign auto_data_s = ch_arr_s[ch_r];

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        dwell_lat_nx_s = dwell_lat_r;
        ch_nx_s        = ch_r;
        data_nx_s      = data_r;
        ch_out_nx_s    = ch_out_r;
        valid_nx_s     = 1'b0;
        done_nx_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (mode_i == MODE_AUTO) begin
                    // data_o/ch_o keep their last manual value until the first capture.
                    state_nx_s     = SETTLE;
                    cnt_nx_s       = {DWELL_W{1'b0}};
                    ch_nx_s        = {SEL_W{1'b0}};
                    dwell_lat_nx_s = dwell_i;
                end else begin
                    data_nx_s   = manual_data_s;
                    ch_out_nx_s = sel_i;
                end
            end
            SETTLE: begin
                if (mode_i == MODE_MANUAL) begin
                    state_nx_s = IDLE;
                    ch_nx_s    = {SEL_W{1'b0}};
                end else if (hold_i) begin
                    state_nx_s = SETTLE;
                end else if (cnt_r == dwell_lat_r) begin
                    state_nx_s = CAPTURE;
                end else begin
                    cnt_nx_s = cnt_r + DWELL_W'(1);
                end
            end
            CAPTURE: begin
                if (mode_i == MODE_MANUAL) begin
                    state_nx_s = IDLE;
                    ch_nx_s    = {SEL_W{1'b0}};
                end else begin
                    state_nx_s     = SETTLE;
                    data_nx_s      = auto_data_s;
                    ch_out_nx_s    = ch_r;
                    valid_nx_s     = 1'b1;
                    done_nx_s      = (ch_r == LAST_CH);
                    ch_nx_s        = (ch_r == LAST_CH) ? {SEL_W{1'b0}} : ch_r + SEL_W'(1);
                    cnt_nx_s       = {DWELL_W{1'b0}};
                    dwell_lat_nx_s = dwell_i;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = {DWELL_W{1'b0}};
                ch_nx_s    = {SEL_W{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {DWELL_W{1'b0}};
            dwell_lat_r <= {DWELL_W{1'b0}};
            ch_r        <= {SEL_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            ch_out_r    <= {SEL_W{1'b0}};
            valid_r     <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            dwell_lat_r <= dwell_lat_nx_s;
            ch_r        <= ch_nx_s;
            data_r      <= data_nx_s;
            ch_out_r    <= ch_out_nx_s;
            valid_r     <= valid_nx_s;
            done_r      <= done_nx_s;
        end
    end

    assign data_o      = data_r;
    assign ch_o        = ch_out_r;
    assign valid_o     = valid_r;
    assign scan_done_o = done_r;

endmodule

// File: tb/tb_tile_scan_mux.sv
// tb_tile_scan_mux
// Self-checking bench for tile_scan_mux (NUM_CH=4, DATA_W=8). Expected auto
// captures are queued when a scan is started and popped on each valid_o.
// Honours TILE_SCAN_SYNC_EN for the manual-path latency.
module tb_tile_scan_mux;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 8;
    localparam int SEL_W   = 2;
    localparam int DWELL_W = 8;
`ifdef TILE_SCAN_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  ch;
        logic              done;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH*DATA_W-1:0] ch_data_i = '0;
    logic                     mode_i = 1'b0;
    logic [SEL_W-1:0]         sel_i = '0;
    logic [DWELL_W-1:0]       dwell_i = '0;
    logic                     hold_i = 1'b0;
    logic [DATA_W-1:0]        data_o;
    logic [SEL_W-1:0]         ch_o;
    logic                     valid_o;
    logic                     scan_done_o;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tile_scan_mux #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_data_i   (ch_data_i),
        .mode_i      (mode_i),
        .sel_i       (sel_i),
        .dwell_i     (dwell_i),
        .hold_i      (hold_i),
        .data_o      (data_o),
        .ch_o        (ch_o),
        .valid_o     (valid_o),
        .scan_done_o (scan_done_o)
    );

    // scan_done_o must never appear without valid_o.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (scan_done_o && !valid_o) begin
                n_fail++;
                $display("FAIL done_without_valid: scan_done_o=%b valid_o=%b required valid_o=1", scan_done_o, valid_o);
            end
        end
    end

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
        ch_data_i = {d3, d2, d1, d0};
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance until valid_o is seen (sampled 1 time unit after each edge).
    task automatic wait_valid(input int budget, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (valid_o !== 1'b1 && edges < budget);
    endtask

    task automatic go_idle();
        mode_i = 1'b0;
        hold_i = 1'b0;
        tick(1);
    endtask

    // Pop one expectation and compare the current capture against it.
    task automatic check_capture(input string name, input int edges, input int exp_edges);
        e = exp_q.pop_front();
        n_checks++;
        if (edges !== exp_edges || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timing: edges=%0d valid=%b required edges=%0d valid=1", name, edges, valid_o, exp_edges);
        end
        n_checks++;
        if ({data_o, ch_o, scan_done_o} !== {e.data, e.ch, e.done}) begin
            n_fail++;
            $display("FAIL %s_data: data=%h ch=%0d done=%b required data=%h ch=%0d done=%b",
                     name, data_o, ch_o, scan_done_o, e.data, e.ch, e.done);
        end
    endtask

    task automatic test_reset();
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        #12;
        n_checks++;
        if ({data_o, ch_o, valid_o, scan_done_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: data=%h ch=%0d valid=%b done=%b required all 0", data_o, ch_o, valid_o, scan_done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        sel_i = 2'd2;
        mode_i = 1'b0;
        tick(LAT + 2);
        n_checks++;
        if ({data_o, ch_o, valid_o} !== {8'h33, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL manual_sel2: data=%h ch=%0d valid=%b required 33/2/0", data_o, ch_o, valid_o);
        end
        sel_i = 2'd0;
        tick(1);
        n_checks++;
        if ({data_o, ch_o} !== {8'h11, 2'd0}) begin
            n_fail++;
            $display("FAIL manual_sel0: data=%h ch=%0d required 11/0", data_o, ch_o);
        end
        set_data(8'h5A, 8'h22, 8'h33, 8'h44);
        tick(LAT - 1);
        n_checks++;
        if (data_o !== 8'h11) begin
            n_fail++;
            $display("FAIL manual_latency_early: data=%h required 11", data_o);
        end
        tick(1);
        n_checks++;
        if (data_o !== 8'h5A) begin
            n_fail++;
            $display("FAIL manual_latency: data=%h required 5a", data_o);
        end
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        tick(LAT + 1);
    endtask

    task automatic test_auto();
        int edges;
        dwell_i = 8'd2;
        exp_q.push_back('{8'h11, 2'd0, 1'b0});
        exp_q.push_back('{8'h22, 2'd1, 1'b0});
        exp_q.push_back('{8'h33, 2'd2, 1'b0});
        exp_q.push_back('{8'h44, 2'd3, 1'b1});
        exp_q.push_back('{8'h11, 2'd0, 1'b0});
        mode_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_valid(40, edges);
            // First capture: sampling edge plus dwell+2 further edges.
            check_capture("auto", edges, (k == 0) ? 5 : 4);
        end
        tick(1);
        n_checks++;
        if ({valid_o, scan_done_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL auto_pulse_width: valid=%b done=%b required 0/0", valid_o, scan_done_o);
        end
        go_idle();
    endtask

    task automatic test_hold();
        int edges;
        int seen;
        dwell_i = 8'd2;
        exp_q.push_back('{8'h11, 2'd0, 1'b0});
        exp_q.push_back('{8'h22, 2'd1, 1'b0});
        mode_i = 1'b1;
        wait_valid(40, edges);
        check_capture("hold_ch0", edges, 5);
        hold_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (valid_o) seen++;
        end
        hold_i = 1'b0;
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL hold_no_valid: valids=%0d required 0", seen);
        end
        wait_valid(40, edges);
        check_capture("hold_ch1", edges + 5, 9);
        go_idle();
    endtask

    task automatic test_dwell_change();
        int edges;
        dwell_i = 8'd2;
        exp_q.push_back('{8'h11, 2'd0, 1'b0});
        exp_q.push_back('{8'h22, 2'd1, 1'b0});
        mode_i = 1'b1;
        tick(1);
        dwell_i = 8'd5;
        wait_valid(40, edges);
        check_capture("dwell_ch0", edges, 4);
        wait_valid(40, edges);
        check_capture("dwell_ch1", edges, 7);
        go_idle();
        dwell_i = 8'd2;
    endtask

    task automatic test_mode_drop();
        int edges;
        dwell_i = 8'd2;
        exp_q.push_back('{8'h11, 2'd0, 1'b0});
        exp_q.push_back('{8'h22, 2'd1, 1'b0});
        exp_q.push_back('{8'h33, 2'd2, 1'b0});
        mode_i = 1'b1;
        wait_valid(40, edges);
        check_capture("drop_ch0", edges, 5);
        wait_valid(40, edges);
        check_capture("drop_ch1", edges, 4);
        wait_valid(40, edges);
        check_capture("drop_ch2", edges, 4);
        // Channel 3 counter has reached dwell: capture would be next.
        tick(2);
        mode_i = 1'b0;
        sel_i = 2'd1;
        tick(1);
        n_checks++;
        if ({data_o, ch_o, valid_o} !== {8'h33, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL drop_idle: data=%h ch=%0d valid=%b required 33/2/0", data_o, ch_o, valid_o);
        end
        tick(1);
        n_checks++;
        if ({data_o, ch_o, valid_o} !== {8'h22, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL drop_manual: data=%h ch=%0d valid=%b required 22/1/0", data_o, ch_o, valid_o);
        end
        set_data(8'h11, 8'h77, 8'h33, 8'h44);
        tick(LAT - 1);
        n_checks++;
        if (data_o !== 8'h22) begin
            n_fail++;
            $display("FAIL drop_follow_early: data=%h required 22", data_o);
        end
        tick(1);
        n_checks++;
        if (data_o !== 8'h77) begin
            n_fail++;
            $display("FAIL drop_follow: data=%h required 77", data_o);
        end
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        tick(LAT + 1);
        exp_q.push_back('{8'h11, 2'd0, 1'b0});
        mode_i = 1'b1;
        wait_valid(40, edges);
        check_capture("drop_reentry", edges, 5);
        go_idle();
    endtask

    task automatic test_reset_mid();
        int edges;
        dwell_i = 8'd4;
        exp_q.push_back('{8'h11, 2'd0, 1'b0});
        exp_q.push_back('{8'h22, 2'd1, 1'b0});
        mode_i = 1'b1;
        wait_valid(40, edges);
        check_capture("rstmid_ch0", edges, 7);
        wait_valid(40, edges);
        check_capture("rstmid_ch1", edges, 6);
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({data_o, ch_o, valid_o, scan_done_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: data=%h ch=%0d valid=%b done=%b required all 0", data_o, ch_o, valid_o, scan_done_o);
        end
        mode_i = 1'b0;
        sel_i = 2'd0;
        dwell_i = 8'd2;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        n_checks++;
        if ({ch_o, valid_o} !== {2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_resume_ch: ch=%0d valid=%b required 0/0", ch_o, valid_o);
        end
        sel_i = 2'd1;
        tick(LAT);
        n_checks++;
        if ({data_o, ch_o} !== {8'h22, 2'd1}) begin
            n_fail++;
            $display("FAIL reset_resume_manual: data=%h ch=%0d required 22/1", data_o, ch_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_manual();
        test_auto();
        test_hold();
        test_dwell_change();
        test_mode_drop();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
